// File: rtl/audio_pio_i2s_bridge.sv
// I2S slave bridge between the audio PIO sample words and the WM8731 codec pins.
// The codec drives BCLK and both LRCKs; every pin is resynchronised onto clk.
module audio_pio_i2s_bridge #(
  parameter int DATA_W      = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] dac_word,
  output logic [31:0] adc_word,
  output logic        sample_tick,
  output logic        frame_err,
  input  logic        aud_bclk,
  input  logic        aud_daclrck,
  input  logic        aud_adclrck,
  input  logic        aud_adcdat,
  output logic        aud_dacdat
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {TX_IDLE, TX_DELAY, TX_SHIFT} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_SKIP, RX_CAPTURE} rx_state_t;

  logic [3:0] pins;
  logic [3:0] sync_line;
  logic [3:0] prev_reg;

  // Line order: 0 = bclk, 1 = daclrck, 2 = adclrck, 3 = adcdat.
  assign pins = {aud_adcdat, aud_adclrck, aud_daclrck, aud_bclk};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain_reg;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) chain_reg <= '0;
        else          chain_reg <= {chain_reg[SYNC_STAGES-2:0], pins[gi]};
      end
      assign sync_line[gi] = chain_reg[SYNC_STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev_reg <= '0;
    else          prev_reg <= sync_line;
  end

  logic bclk_rise, bclk_fall, dlr_edge, alr_edge, alr_fall, adc_bit;
  assign bclk_rise = sync_line[0] & ~prev_reg[0];
  assign bclk_fall = ~sync_line[0] & prev_reg[0];
  assign dlr_edge  = sync_line[1] ^ prev_reg[1];
  assign alr_edge  = sync_line[2] ^ prev_reg[2];
  assign alr_fall  = alr_edge & ~sync_line[2];
  assign adc_bit   = sync_line[3];

  tx_state_t         tx_state_reg, tx_state_next;
  logic [DATA_W-1:0] shadow_reg, shadow_next;
  logic [CNT_W-1:0]  tx_cnt_reg, tx_cnt_next;
  logic              dacdat_reg, dacdat_next;

  rx_state_t         rx_state_reg, rx_state_next;
  logic [DATA_W-1:0] rx_shift_reg, rx_shift_next;
  logic [CNT_W-1:0]  rx_cnt_reg, rx_cnt_next;
  logic [31:0]       adc_word_reg, adc_word_next;
  logic              tick_reg, tick_next;
  logic              err_reg, err_next;

  // Transmit: an LRCK edge reloads the shadow and wins over a coincident BCLK fall,
  // so the MSB lands on the second BCLK fall of the slot.
  always_comb begin
    tx_state_next = tx_state_reg;
    shadow_next   = shadow_reg;
    tx_cnt_next   = tx_cnt_reg;
    dacdat_next   = dacdat_reg;
    if (dlr_edge) begin
      shadow_next   = dac_word[DATA_W-1:0];
      tx_cnt_next   = '0;
      tx_state_next = TX_DELAY;
    end else if (bclk_fall) begin
      case (tx_state_reg)
        TX_DELAY, TX_SHIFT: begin
          if (tx_cnt_reg == CNT_W'(DATA_W)) begin
            dacdat_next   = 1'b0;
            tx_state_next = TX_IDLE;
          end else begin
            dacdat_next   = shadow_reg[DATA_W-1];
            shadow_next   = {shadow_reg[DATA_W-2:0], 1'b0};
            tx_cnt_next   = tx_cnt_reg + 1'b1;
            tx_state_next = TX_SHIFT;
          end
        end
        default: ;
      endcase
    end
  end

  // Receive: only the left slot is captured; any LRCK edge inside a slot is a short slot.
  always_comb begin
    rx_state_next = rx_state_reg;
    rx_shift_next = rx_shift_reg;
    rx_cnt_next   = rx_cnt_reg;
    adc_word_next = adc_word_reg;
    tick_next     = 1'b0;
    err_next      = 1'b0;
    if (alr_edge) begin
      if (rx_state_reg != RX_IDLE) err_next = 1'b1;
      if (alr_fall) begin
        rx_state_next = RX_SKIP;
        rx_shift_next = '0;
        rx_cnt_next   = '0;
      end else begin
        rx_state_next = RX_IDLE;
      end
    end else if (bclk_rise) begin
      case (rx_state_reg)
        RX_SKIP: rx_state_next = RX_CAPTURE;
        RX_CAPTURE: begin
          rx_shift_next = {rx_shift_reg[DATA_W-2:0], adc_bit};
          rx_cnt_next   = rx_cnt_reg + 1'b1;
          if (rx_cnt_reg == CNT_W'(DATA_W - 1)) begin
            adc_word_next = 32'($signed(rx_shift_next));
            tick_next     = 1'b1;
            rx_state_next = RX_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_reg <= TX_IDLE;
      shadow_reg   <= '0;
      tx_cnt_reg   <= '0;
      dacdat_reg   <= 1'b0;
      rx_state_reg <= RX_IDLE;
      rx_shift_reg <= '0;
      rx_cnt_reg   <= '0;
      adc_word_reg <= '0;
      tick_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      tx_state_reg <= tx_state_next;
      shadow_reg   <= shadow_next;
      tx_cnt_reg   <= tx_cnt_next;
      dacdat_reg   <= dacdat_next;
      rx_state_reg <= rx_state_next;
      rx_shift_reg <= rx_shift_next;
      rx_cnt_reg   <= rx_cnt_next;
      adc_word_reg <= adc_word_next;
      tick_reg     <= tick_next;
      err_reg      <= err_next;
    end
  end

  assign adc_word    = adc_word_reg;
  assign sample_tick = tick_reg;
  assign frame_err   = err_reg;
  assign aud_dacdat  = dacdat_reg;

endmodule

// File: tb/tb_audio_pio_i2s_bridge.sv
// Bench for audio_pio_i2s_bridge: a codec model drives 64-BCLK I2S frames, scoreboards
// hold expected ADC words and DAC slot contents, and monitors compare as the DUT produces them.
module tb_audio_pio_i2s_bridge;
  localparam int HALF = 160;  // half BCLK = 8 clk at 50 MHz

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] dac_word = 32'h0;
  logic [31:0] adc_word;
  logic        sample_tick, frame_err;
  logic        aud_bclk = 1'b1, aud_daclrck = 1'b1, aud_adclrck = 1'b1, aud_adcdat = 1'b0;
  logic        aud_dacdat;

  audio_pio_i2s_bridge #(.DATA_W(24), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .dac_word(dac_word), .adc_word(adc_word),
    .sample_tick(sample_tick), .frame_err(frame_err), .aud_bclk(aud_bclk),
    .aud_daclrck(aud_daclrck), .aud_adclrck(aud_adclrck), .aud_adcdat(aud_adcdat),
    .aud_dacdat(aud_dacdat)
  );

  always #10 clk = ~clk;

  typedef struct { bit chk; logic [23:0] w; } tx_exp_t;
  tx_exp_t     tx_q[$];
  logic [31:0] adc_q[$];
  logic [31:0] last_adc = 32'h0;
  int checks = 0, errors = 0;
  int exp_err = 0, got_err = 0;

  function automatic logic [31:0] sext24(input logic [23:0] v);
    int s;
    s = int'(v);
    if (s >= 8388608) s = s - 16777216;
    return 32'(s);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Codec model: one slot of nbits BCLKs; LRCK and data change on BCLK falls.
  task automatic run_slot(input bit lr, input int nbits, input logic [23:0] adc,
                          input bit adc_exp, input bit tx_chk, input int rst_at,
                          input int chg_at, input logic [31:0] new_dac);
    tx_exp_t e;
    for (int i = 0; i < nbits; i++) begin
      aud_bclk = 1'b0;
      if (i == 0) begin
        aud_daclrck = lr;
        aud_adclrck = lr;
        aud_adcdat  = 1'b0;
        e.chk = tx_chk;
        e.w   = dac_word[23:0];
        tx_q.push_back(e);
        if (adc_exp) begin
          adc_q.push_back(sext24(adc));
          last_adc = sext24(adc);
        end
      end else begin
        aud_adcdat = (i <= 24) ? adc[24-i] : 1'b0;
      end
      if (i == chg_at) dac_word = new_dac;
      if (i == rst_at) begin
        #20 reset_n = 1'b0;
        #1;
        chk("rst_mid_adc_word", adc_word, 32'h0);
        chk("rst_mid_dacdat", {31'h0, aud_dacdat}, 32'h0);
        #59 reset_n = 1'b1;
        last_adc = 32'h0;
        #80;
      end else begin
        #HALF;
      end
      aud_bclk = 1'b1;
      #HALF;
    end
  endtask

  task automatic run_frame(input logic [23:0] l, input logic [23:0] r,
                           input int chg_at, input logic [31:0] new_dac);
    run_slot(1'b0, 32, l, 1'b1, 1'b1, -1, chg_at, new_dac);
    run_slot(1'b1, 32, r, 1'b0, 1'b1, -1, -1, 32'h0);
  endtask

  // RX monitor: every sample_tick pops one expected ADC word.
  logic prev_tick = 1'b0, prev_err = 1'b0;
  always @(negedge clk) begin
    if (sample_tick) begin
      if (adc_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tick_unexpected: adc_word %h, no sample expected", adc_word);
      end else begin
        chk("adc_word", adc_word, adc_q.pop_front());
      end
      chk("tick_width", {31'h0, prev_tick}, 32'h0);
    end
    if (frame_err) begin
      got_err++;
      chk("err_width", {31'h0, prev_err}, 32'h0);
    end
    prev_tick = sample_tick;
    prev_err  = frame_err;
  end

  // TX monitor: codec-side receiver sampling aud_dacdat on BCLK rises.
  logic bits[64];
  task automatic finalize(input int n);
    tx_exp_t     e;
    logic [23:0] w;
    logic        nz;
    if (tx_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL tx_slot_unexpected: slot of %0d bits, none expected", n);
      return;
    end
    e = tx_q.pop_front();
    if (!e.chk) return;
    w  = '0;
    nz = 1'b0;
    for (int k = 1; k <= 24; k++) w = {w[22:0], bits[k]};
    for (int k = 25; k < n && k < 64; k++) if (bits[k] !== 1'b0) nz = 1'b1;
    chk("tx_slot_word", {8'h0, w}, {8'h0, e.w});
    chk("tx_slot_tail", {31'h0, nz}, 32'h0);
  endtask

  initial begin
    logic last_lr;
    bit   active;
    int   idx;
    last_lr = 1'b1;
    active  = 1'b0;
    idx     = 0;
    forever begin
      @(posedge aud_bclk);
      if (aud_daclrck !== last_lr) begin
        if (active) finalize(idx);
        active  = 1'b1;
        idx     = 0;
        last_lr = aud_daclrck;
      end
      if (idx < 64) bits[idx] = aud_dacdat;
      idx++;
    end
  end

  initial begin
    logic [23:0] l, r;
    dac_word = 32'h00A55A3C;
    #3;
    // All pins toggle while reset is held.
    run_slot(1'b0, 32, 24'h5A5A5A, 1'b0, 1'b0, -1, -1, 32'h0);
    chk("rst_adc_word", adc_word, 32'h0);
    chk("rst_dacdat", {31'h0, aud_dacdat}, 32'h0);
    chk("rst_tick", {31'h0, sample_tick}, 32'h0);
    chk("rst_err", {31'h0, frame_err}, 32'h0);
    reset_n = 1'b1;
    run_slot(1'b1, 32, 24'h0F0F0F, 1'b0, 1'b0, -1, -1, 32'h0);

    run_frame(24'h800001, 24'h123456, -1, 32'h0);
    run_frame(24'h800001, 24'h123456, -1, 32'h0);
    run_frame(24'h7FFFFF, 24'h123456, -1, 32'h0);

    // dac_word changes at bit 10 of the left slot.
    dac_word = 32'h00000001;
    run_frame(24'h000000, 24'h000000, 10, 32'h007FFFFF);

    // Short slot on both LRCKs after 12 captured bits.
    dac_word = 32'hFF00C3A5;
    run_slot(1'b0, 13, 24'hABCDEF, 1'b0, 1'b0, -1, -1, 32'h0);
    exp_err++;
    run_slot(1'b1, 32, 24'h111111, 1'b0, 1'b1, -1, -1, 32'h0);
    chk("short_adc_unchanged", adc_word, last_adc);
    run_frame(24'h3C3C3C, 24'h222222, -1, 32'h0);

    // Reset pulse at bit 7 of the left slot.
    run_slot(1'b0, 32, 24'h654321, 1'b0, 1'b0, 7, -1, 32'h0);
    run_slot(1'b1, 32, 24'h333333, 1'b0, 1'b0, -1, -1, 32'h0);
    chk("post_rst_adc_word", adc_word, 32'h0);
    run_frame(24'hC0FFEE, 24'h444444, -1, 32'h0);

    for (int f = 0; f < 12; f++) begin
      dac_word = $urandom;
      l = 24'($urandom);
      r = 24'($urandom);
      run_frame(l, r, int'($urandom_range(2, 30)), $urandom);
    end

    // Start one more slot so the last full slot is closed by the monitor.
    run_slot(1'b0, 4, 24'h0, 1'b0, 1'b0, -1, -1, 32'h0);
    #1000;
    chk("adc_q_drained", 32'(adc_q.size()), 32'h0);
    chk("tx_q_drained", 32'(tx_q.size()), 32'h1);
    chk("frame_err_count", 32'(got_err), 32'(exp_err));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
